// File: rtl/axil_read_config_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : read_config_i
//  Description : Request/response interface between the AXI-Lite read bridge
//                and the read config splitter. Addresses are word indices.
//  Revision    : 1.0 - initial release
// ============================================================================
interface read_config_i #(
  parameter int ADDR_BITS = 30,
  parameter int DATA_BITS = 32
);
  logic [ADDR_BITS-1:0] read_addr;
  logic                 read_valid;
  logic                 read_ready;
  logic [DATA_BITS-1:0] resp_data;
  logic                 resp_error;
  logic                 resp_valid;
  logic                 resp_ready;

  // Bridge side: issues requests, accepts responses
  modport m (
    output read_addr, read_valid, resp_ready,
    input  read_ready, resp_data, resp_error, resp_valid
  );

  // Splitter side: accepts requests, returns responses
  modport s (
    input  read_addr, read_valid, resp_ready,
    output read_ready, resp_data, resp_error, resp_valid
  );
endinterface
`default_nettype wire

// File: rtl/axil_read_config_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axil_read_config_bridge
//  Description : AXI-Lite read slave that forwards aligned reads to a word
//                addressed request/response port, tracks outstanding reads,
//                answers misaligned reads in order with SLVERR and counts
//                returned SLVERR beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_read_config_bridge #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int AXIL_ADDR_BITS  = 32,
  parameter int AXIL_DATA_BITS  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXIL_ADDR_BITS-1:0] s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [AXIL_DATA_BITS-1:0] s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  read_config_i.m                   out,
  output logic [15:0]               err_count
);

  localparam int              CNT_W         = $clog2(MAX_OUTSTANDING + 1);
  localparam int              WORD_W        = AXIL_ADDR_BITS - 2;
  localparam logic [CNT_W-1:0] C_MAX_CNT    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [1:0]      C_RESP_OKAY   = 2'b00;
  localparam logic [1:0]      C_RESP_SLVERR = 2'b10;

  logic                      req_valid_q, req_valid_d;
  logic [WORD_W-1:0]         req_addr_q,  req_addr_d;
  logic [CNT_W-1:0]          cnt_q,       cnt_d;
  logic                      pend_err_q,  pend_err_d;
  logic                      rvalid_q,    rvalid_d;
  logic [AXIL_DATA_BITS-1:0] rdata_q,     rdata_d;
  logic [1:0]                rresp_q,     rresp_d;
  logic [15:0]               err_count_q, err_count_d;

  logic w_aligned, w_ar_fire, w_issue, w_out_free, w_emit_local;
  logic w_resp_ready, w_resp_fire, w_dec, w_r_fire;

  // Handshake qualifiers; a local error is emitted only once every earlier read has drained
  always_comb begin
    w_aligned    = (s_araddr[1:0] == 2'b00);
    w_out_free   = !rvalid_q || s_rready;
    w_emit_local = pend_err_q && (cnt_q == '0) && !req_valid_q && w_out_free;
    w_resp_ready = !rst && w_out_free && !w_emit_local;
    s_arready    = !rst && !req_valid_q && (cnt_q < C_MAX_CNT) && !pend_err_q;
    w_ar_fire    = s_arvalid && s_arready;
    w_issue      = !rst && req_valid_q && out.read_ready;
    w_resp_fire  = out.resp_valid && w_resp_ready;
    w_dec        = w_resp_fire && (cnt_q != '0);
    w_r_fire     = !rst && rvalid_q && s_rready;
  end

  // Next-state for request register, outstanding counter, error flag and R register
  always_comb begin
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    pend_err_d  = pend_err_q;
    cnt_d       = cnt_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    err_count_d = err_count_q;

    if (w_ar_fire && w_aligned) begin
      req_valid_d = 1'b1;
      req_addr_d  = s_araddr[AXIL_ADDR_BITS-1:2];
    end else if (w_issue) begin
      req_valid_d = 1'b0;
    end

    if (w_ar_fire && !w_aligned) begin
      pend_err_d = 1'b1;
    end else if (w_emit_local) begin
      pend_err_d = 1'b0;
    end

    // Simultaneous issue and return leave the count unchanged; never underflow
    if (w_issue && !w_dec) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!w_issue && w_dec) begin
      cnt_d = cnt_q - 1'b1;
    end

    if (w_emit_local) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = C_RESP_SLVERR;
    end else if (w_resp_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = out.resp_data;
      rresp_d  = out.resp_error ? C_RESP_SLVERR : C_RESP_OKAY;
    end else if (s_rready) begin
      rvalid_d = 1'b0;
    end

    if (w_r_fire && (rresp_q == C_RESP_SLVERR) && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      cnt_q       <= '0;
      pend_err_q  <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= 2'b00;
      err_count_q <= 16'd0;
    end else begin
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      cnt_q       <= cnt_d;
      pend_err_q  <= pend_err_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      err_count_q <= err_count_d;
    end
  end

  // A downstream response with nothing outstanding is a protocol violation
  always_ff @(posedge clk) begin
    if (!rst && w_resp_fire) begin
      assert (cnt_q != '0);
    end
  end

  // Outputs are forced to their idle values for as long as reset is held
  assign s_rvalid       = rvalid_q && !rst;
  assign s_rdata        = rst ? '0 : rdata_q;
  assign s_rresp        = rst ? 2'b00 : rresp_q;
  assign err_count      = rst ? 16'd0 : err_count_q;
  assign out.read_valid = req_valid_q && !rst;
  assign out.read_addr  = rst ? '0 : req_addr_q;
  assign out.resp_ready = w_resp_ready;

endmodule
`default_nettype wire

// File: tb/tb_axil_read_config_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_read_config_bridge
//  Description : Directed scoreboard bench for axil_read_config_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_read_config_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [15:0] err_count;

  read_config_i #(.ADDR_BITS(30), .DATA_BITS(32)) rc ();

  axil_read_config_bridge #(
    .MAX_OUTSTANDING(4),
    .AXIL_ADDR_BITS (32),
    .AXIL_DATA_BITS (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_araddr (s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rvalid (s_rvalid),
    .s_rready (s_rready),
    .out      (rc),
    .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_r[$];     // {rresp, rdata}
  logic [29:0] exp_addr[$];
  logic [33:0] mon_r;
  logic [29:0] mon_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares R beats and downstream issues against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (s_rvalid && s_rready) begin
        if (exp_r.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_unexpected: got data 0x%0h resp %0d, none expected", s_rdata, s_rresp);
        end else begin
          mon_r = exp_r.pop_front();
          chk("r_data", 64'(s_rdata), 64'(mon_r[31:0]));
          chk("r_resp", 64'(s_rresp), 64'(mon_r[33:32]));
        end
      end
      if (rc.read_valid && rc.read_ready) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL issue_unexpected: got read_addr 0x%0h, none expected", rc.read_addr);
        end else begin
          mon_a = exp_addr.pop_front();
          chk("read_addr", 64'(rc.read_addr), 64'(mon_a));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input logic [31:0] a);
    int n = 0;
    if (a[1:0] == 2'b00) exp_addr.push_back(a[31:2]);
    s_araddr  = a;
    s_arvalid = 1'b1;
    @(negedge clk);
    while (!s_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accept", 64'(s_arready), 64'd1);
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] d, input logic e);
    int n = 0;
    exp_r.push_back({(e ? 2'b10 : 2'b00), d});
    rc.resp_valid = 1'b1;
    rc.resp_data  = d;
    rc.resp_error = e;
    @(negedge clk);
    while (!rc.resp_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("resp_accept", 64'(rc.resp_ready), 64'd1);
    @(posedge clk);
    #1;
    rc.resp_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_arready"},    64'(s_arready),     64'd0);
    chk({tag, "_rvalid"},     64'(s_rvalid),      64'd0);
    chk({tag, "_rdata"},      64'(s_rdata),       64'd0);
    chk({tag, "_read_valid"}, 64'(rc.read_valid), 64'd0);
    chk({tag, "_read_addr"},  64'(rc.read_addr),  64'd0);
    chk({tag, "_resp_ready"}, 64'(rc.resp_ready), 64'd0);
    chk({tag, "_err_count"},  64'(err_count),     64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    s_araddr      = '0;
    s_arvalid     = 1'b0;
    s_rready      = 1'b1;
    rc.read_ready = 1'b1;
    rc.resp_valid = 1'b0;
    rc.resp_data  = '0;
    rc.resp_error = 1'b0;

    // Reset state
    cyc(3);
    @(negedge clk);
    chk_idle("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("first_arready", 64'(s_arready), 64'd1);

    // Single aligned read with a 2-cycle downstream stall on read_ready
    @(posedge clk);
    #1;
    rc.read_ready = 1'b0;
    do_ar(32'h10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_read_valid", 64'(rc.read_valid), 64'd1);
      chk("stall_read_addr",  64'(rc.read_addr),  64'd4);
      @(posedge clk);
      #1;
    end
    rc.read_ready = 1'b1;
    cyc(2);
    resp(32'hDEADBEEF, 1'b0);
    chk("lat_rvalid", 64'(s_rvalid), 64'd1);
    chk("lat_rdata",  64'(s_rdata),  64'hDEADBEEF);
    chk("lat_rresp",  64'(s_rresp),  64'd0);
    cyc(2);

    // Outstanding limit
    for (int i = 0; i < 4; i++) do_ar(32'(i * 4));
    cyc(2);
    chk("limit_arready", 64'(s_arready), 64'd0);
    cyc(2);
    chk("limit_arready_hold", 64'(s_arready), 64'd0);
    resp(32'h0000_1000, 1'b0);
    chk("limit_arready_free", 64'(s_arready), 64'd1);
    do_ar(32'h10);
    cyc(2);
    resp(32'h0000_1001, 1'b0);
    resp(32'h0000_1002, 1'b0);
    resp(32'h0000_1003, 1'b0);
    resp(32'h0000_1004, 1'b0);
    cyc(2);

    // Misaligned read behind two outstanding reads
    do_ar(32'h20);
    do_ar(32'h24);
    cyc(2);
    do_ar(32'h6);
    chk("mis_arready", 64'(s_arready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mis_no_issue", 64'(rc.read_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    resp(32'hA1A1_0001, 1'b0);
    resp(32'hA1A1_0002, 1'b0);
    exp_r.push_back({2'b10, 32'h0});
    cyc(4);
    chk("mis_err_count", 64'(err_count), 64'd1);

    // Downstream error
    do_ar(32'h30);
    cyc(2);
    resp(32'h0000_0055, 1'b1);
    cyc(3);
    chk("dserr_err_count", 64'(err_count), 64'd2);

    // Backpressure on R with a second response waiting
    do_ar(32'h40);
    do_ar(32'h44);
    cyc(2);
    resp(32'hCAFE_F00D, 1'b0);
    s_rready      = 1'b0;
    rc.resp_valid = 1'b1;
    rc.resp_data  = 32'h1234_5678;
    rc.resp_error = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rvalid",     64'(s_rvalid),      64'd1);
      chk("bp_rdata",      64'(s_rdata),       64'hCAFEF00D);
      chk("bp_rresp",      64'(s_rresp),       64'd0);
      chk("bp_resp_ready", 64'(rc.resp_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    s_rready = 1'b1;
    resp(32'h1234_5678, 1'b0);
    cyc(3);

    // Reset with three reads outstanding
    do_ar(32'h50);
    do_ar(32'h54);
    do_ar(32'h58);
    cyc(2);
    rst           = 1'b1;
    rc.resp_valid = 1'b1;
    rc.resp_data  = 32'hBAD0_BAD0;
    @(negedge clk);
    chk_idle("mid_rst");
    cyc(2);
    rst           = 1'b0;
    rc.resp_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_arready",   64'(s_arready), 64'd1);
    chk("post_rst_err_count", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) do_ar(32'h60 + 32'(i * 4));
    cyc(2);
    chk("post_rst_full", 64'(s_arready), 64'd0);
    resp(32'h0000_0077, 1'b0);
    resp(32'h0000_0078, 1'b0);
    resp(32'h0000_0079, 1'b0);
    resp(32'h0000_007A, 1'b0);
    cyc(4);

    chk("exp_r_drained",    64'(exp_r.size()),    64'd0);
    chk("exp_addr_drained", 64'(exp_addr.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axil_read_config_bridge.md
AXIL_READ_CONFIG_BRIDGE -- requirements
Module: axil_read_config_bridge

Interface
REQ-001 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of reads issued downstream but not yet answered (range 1..64).
REQ-002 The block SHALL have parameter AXIL_ADDR_BITS, default 32, meaning the AXI-Lite byte-address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports s_araddr (input, AXIL_ADDR_BITS), s_arvalid (input, 1) and s_arready (output, 1): the AXI-Lite read-address channel.
REQ-006 The block SHALL have ports s_rdata (output, AXIL_DATA_BITS), s_rresp (output, 2), s_rvalid (output, 1) and s_rready (input, 1): the AXI-Lite read-data channel.
REQ-007 The block SHALL have port out, read_config_i.m: the downstream request/response interface, which feeds the read config splitter.
REQ-008 The block SHALL have port err_count, output, 16 bits: saturating count of SLVERR responses returned.

Function
REQ-009 The block SHALL derive the word index as s_araddr >> 2; it is an aligned request if s_araddr[1:0] == 0, otherwise misaligned.
REQ-010 The block SHALL hold an outstanding counter cnt (0..MAX_OUTSTANDING).
REQ-011 The block SHALL assert s_arready only when all of these hold: rst is low; the request register is empty; cnt < MAX_OUTSTANDING; and the pending-local-error flag is clear.
REQ-012 The block SHALL load an accepted aligned AR into a one-entry request register that drives out.read_addr and out.read_valid.
REQ-013 The block SHALL hold out.read_addr stable while out.read_valid is high and out.read_ready is low.
REQ-014 The block SHALL increment cnt on the out.read_valid && out.read_ready handshake.
REQ-015 The block SHALL set the pending-local-error flag on an accepted misaligned AR and SHALL NOT issue a downstream read for it.
REQ-016 The block SHALL answer a misaligned AR only after cnt == 0 and the request register is empty (in-order return), with s_rdata = 0 and s_rresp = 2'b10.
REQ-017 The block SHALL hold the read-data channel in a one-entry output register.
REQ-018 The block SHALL drive out.resp_ready = !s_rvalid || s_rready, and SHALL drive out.resp_ready low while a pending local error is being emitted.
REQ-019 On the out.resp_valid && out.resp_ready handshake, the block SHALL load s_rdata = out.resp_data and s_rresp = out.resp_error ? 2'b10 : 2'b00, set s_rvalid, and decrement cnt.
REQ-020 The block SHALL change s_rvalid, s_rdata and s_rresp only when !s_rvalid || s_rready.
REQ-021 The block SHALL add zero cycles of response latency beyond one register: the R beat is visible the cycle after the downstream response handshake.
REQ-022 With s_rready held high, the block SHALL sustain one response per cycle.
REQ-023 If an issue and a return handshake occur in the same cycle, cnt SHALL be unchanged.
REQ-024 A downstream response with cnt == 0 is a protocol violation; a simulation assertion SHALL fire and cnt SHALL NOT underflow.
REQ-025 The block SHALL increment err_count on each R handshake with s_rresp == 2'b10, saturating at 16'hFFFF.

Reset
REQ-026 While rst is high, the block SHALL drive s_arready = 0, s_rvalid = 0, s_rdata = 0, s_rresp = 0, out.read_valid = 0, out.read_addr = 0 and out.resp_ready = 0, and SHALL clear cnt, err_count, the request register and the pending-local-error flag.
REQ-027 Reset asserted mid-transaction SHALL discard all in-flight state; downstream responses arriving after reset are not forwarded (resp_ready is low during reset).
REQ-028 The first s_arready assertion SHALL occur in the cycle after rst deasserts.

Verification
REQ-029 The bench SHALL apply a single aligned read: araddr = 0x10 -> out.read_addr = 4; downstream returns 0xDEADBEEF -> s_rdata = 0xDEADBEEF, s_rresp = 0, one cycle later.
REQ-030 The bench SHALL issue back-to-back aligned reads at 0x0, 0x4, 0x8, 0xC, 0x10 with the downstream stalling responses -> after 4 issues s_arready = 0 (MAX_OUTSTANDING = 4), and the 5th is accepted after the first response.
REQ-031 The bench SHALL apply a misaligned read at 0x6 while 2 reads are outstanding -> no downstream request; SLVERR with rdata 0 is returned after both OKAY responses; err_count = 1.
REQ-032 The bench SHALL return resp_error = 1 from downstream -> s_rresp = 2'b10 and err_count increments.
REQ-033 The bench SHALL hold s_rready low for 5 cycles with s_rvalid high -> s_rdata and s_rresp stable, out.resp_ready = 0, and no response lost.
REQ-034 The bench SHALL assert rst with 3 reads outstanding -> all outputs reach reset values next cycle and cnt = 0; a subsequent read completes normally.
